// File: rtl/fifo_pkg.sv
// Shared definitions for the fifo block and its pop-side reader.
//   WIDTH      : data word width of fifo data_out
//   SKID_DEPTH : entries in the reader's skid buffer
//   CNT_W_DEF  : default width of the reader's delivered-word counter
//   reader_state_t : fifo_pop_reader control states
package fifo_pkg;

  localparam int unsigned WIDTH      = 8;
  localparam int unsigned SKID_DEPTH = 3;
  localparam int unsigned CNT_W_DEF  = 16;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    STOP,
    ERR
  } reader_state_t;

endpackage

// File: rtl/fifo_pop_reader_if.sv
// Handshake bundle between fifo (pop side), fifo_pop_reader and the stream sink.
//   fifo_empty/fifo_data_out/fifo_error : fifo -> reader
//   fifo_pop                            : reader -> fifo
//   m_valid/m_data                      : reader -> sink
//   m_ready                             : sink -> reader
// master = the reader, slave = the environment (fifo + sink).
interface fifo_pop_reader_if #(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH
);

  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data_out;
  logic             fifo_error;
  logic             fifo_pop;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  modport master (
    input  fifo_empty, fifo_data_out, fifo_error, m_ready,
    output fifo_pop, m_valid, m_data
  );

  modport slave (
    output fifo_empty, fifo_data_out, fifo_error, m_ready,
    input  fifo_pop, m_valid, m_data
  );

endinterface

// File: rtl/fifo_skid_buf.sv
// 3-entry circular skid buffer for fifo_pop_reader.
//   clk, reset_n : clock, synchronous active-low reset
//   wr_i/wr_data_i : enqueue one word
//   rd_i         : dequeue the head word (ignored when empty)
//   flush_i      : drop all contents and rewind the pointers
//   occ_o        : current occupancy (0..3)
//   head_o       : head entry, 0 when empty
module fifo_skid_buf
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_i,
  input  logic             flush_i,
  output logic [1:0]       occ_o,
  output logic [WIDTH-1:0] head_o
);

  typedef logic [1:0] ptr_t;

  logic [WIDTH-1:0] mem_q [SKID_DEPTH];
  ptr_t             wr_ptr_q, wr_ptr_d;
  ptr_t             rd_ptr_q, rd_ptr_d;
  logic [1:0]       occ_q, occ_d;
  logic             rd_ok;

  function automatic ptr_t ptr_inc(input ptr_t p);
    return (p == ptr_t'(SKID_DEPTH - 1)) ? '0 : p + ptr_t'(1);
  endfunction

  assign rd_ok = rd_i && (occ_q != '0);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (wr_i)  wr_ptr_d = ptr_inc(wr_ptr_q);
      if (rd_ok) rd_ptr_d = ptr_inc(rd_ptr_q);
      case ({wr_i, rd_ok})
        2'b10:   occ_d = occ_q + 2'd1;
        2'b01:   occ_d = occ_q - 2'd1;
        default: occ_d = occ_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: entries are only observed while occ_q != 0.
  always_ff @(posedge clk) begin
    if (wr_i && !flush_i) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign occ_o  = occ_q;
  assign head_o = (occ_q == '0) ? '0 : mem_q[rd_ptr_q];

  // The reader's pop rule reserves space before issuing a pop.
  a_no_overflow : assert property (@(posedge clk) disable iff (!reset_n)
    !(wr_i && !flush_i && (occ_q == 2'(SKID_DEPTH))));

endmodule

// File: rtl/fifo_pop_reader.sv
// Autonomous pop-side consumer for fifo: drains it into a valid/ready stream.
//   clk, reset_n : clock, synchronous active-low reset
//   enable       : 1 = keep issuing pops, 0 = stop and drain
//   flush        : pulse, discard buffered and in-flight words
//   err_clr      : pulse, clear sticky err and leave ERR
//   bus          : fifo pop side + stream (master modport)
//   word_cnt     : words accepted by the sink, wraps mod 2^CNT_W
//   err          : sticky fifo_error indication
//   busy         : not idle, or words buffered / in flight
module fifo_pop_reader
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH = fifo_pkg::WIDTH,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               enable,
  input  logic               flush,
  input  logic               err_clr,
  fifo_pop_reader_if.master  bus,
  output logic [CNT_W-1:0]   word_cnt,
  output logic               err,
  output logic               busy
);

  reader_state_t    state_q;
  logic             inflight_q;
  logic             err_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       occ;
  logic [WIDTH-1:0] head;
  logic             room;
  logic             pop;
  logic             hs;

  // Space is reserved for the word already in flight, so the pop decision
  // uses only registered terms and never depends on m_ready.
  assign room = ({1'b0, occ} + {2'b00, inflight_q}) < 3'(SKID_DEPTH);
  assign pop  = reset_n && (state_q == RUN) && !bus.fifo_empty && room;
  assign hs   = bus.m_valid && bus.m_ready;

  fifo_skid_buf #(
    .WIDTH (WIDTH)
  ) u_skid (
    .clk       (clk),
    .reset_n   (reset_n),
    .wr_i      (inflight_q && !flush),
    .wr_data_i (bus.fifo_data_out),
    .rd_i      (hs),
    .flush_i   (flush),
    .occ_o     (occ),
    .head_o    (head)
  );

  always_comb begin
    cnt_d = cnt_q;
    if (hs) cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      err_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      inflight_q <= pop;
      cnt_q      <= cnt_d;
      if (bus.fifo_error) begin
        state_q <= ERR;
        err_q   <= 1'b1;
      end else begin
        case (state_q)
          IDLE: if (enable && !err_q) state_q <= RUN;
          RUN:  if (!enable) state_q <= STOP;
          STOP: begin
            if (enable)                         state_q <= RUN;
            else if (!inflight_q && occ == '0)  state_q <= IDLE;
          end
          ERR: begin
            if (err_clr) begin
              state_q <= IDLE;
              err_q   <= 1'b0;
            end
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

  // Outputs are forced low during reset so a mid-burst reset issues no pop.
  assign bus.fifo_pop = pop;
  assign bus.m_valid  = reset_n && (occ != '0);
  assign bus.m_data   = reset_n ? head : '0;
  assign word_cnt     = cnt_q;
  assign err          = err_q;
  assign busy         = reset_n && ((state_q != IDLE) || (occ != '0) || inflight_q);

endmodule
